// File: rtl/riscv_core_trap_pkg.sv
// Shared types and constants for the M-mode trap/return sequencer.
// CSR addresses, cause codes and mstatus field positions live here.
package riscv_core_trap_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_EPC,
    S_W_CAUSE,
    S_W_TVAL,
    S_W_STATUS,
    S_W_RESTORE,
    S_REDIRECT
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [4:0] CAUSE_MSI     = 5'd3;
  localparam logic [4:0] CAUSE_MTI     = 5'd7;
  localparam logic [4:0] CAUSE_MEI     = 5'd11;
  localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
  localparam logic [4:0] CAUSE_BREAK   = 5'd3;
  localparam logic [4:0] CAUSE_ECALL   = 5'd11;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;

endpackage

// File: rtl/riscv_core_trap_sequencer_if.sv
// Commit-side bundle between the core and the trap sequencer.
// master = core/pipeline side, slave = sequencer.
interface riscv_core_trap_sequencer_if #(
  parameter int XLEN = 64
);
  logic            i_trap_commit_valid;
  logic [XLEN-1:0] i_trap_pc;
  logic [31:0]     i_trap_instr;
  logic            i_trap_ecall;
  logic            i_trap_ebreak;
  logic            i_trap_mret;
  logic            i_trap_illegal;
  logic [XLEN-1:0] i_trap_mstatus;
  logic [XLEN-1:0] i_trap_mie;
  logic [XLEN-1:0] i_trap_mip;
  logic [XLEN-1:0] i_trap_mtvec;
  logic [XLEN-1:0] i_trap_mepc;
  logic            o_trap_csr_we;
  logic [11:0]     o_trap_csr_waddr;
  logic [XLEN-1:0] o_trap_csr_wdata;
  logic            o_trap_stall;
  logic            o_trap_flush;
  logic            o_trap_redirect_valid;
  logic [XLEN-1:0] o_trap_redirect_pc;
  logic            i_trap_redirect_ready;

  modport master (
    output i_trap_commit_valid, i_trap_pc, i_trap_instr,
    output i_trap_ecall, i_trap_ebreak, i_trap_mret,
    output i_trap_illegal, i_trap_mstatus, i_trap_mie,
    output i_trap_mip, i_trap_mtvec, i_trap_mepc,
    output i_trap_redirect_ready,
    input  o_trap_csr_we, o_trap_csr_waddr, o_trap_csr_wdata,
    input  o_trap_stall, o_trap_flush,
    input  o_trap_redirect_valid, o_trap_redirect_pc
  );

  modport slave (
    input  i_trap_commit_valid, i_trap_pc, i_trap_instr,
    input  i_trap_ecall, i_trap_ebreak, i_trap_mret,
    input  i_trap_illegal, i_trap_mstatus, i_trap_mie,
    input  i_trap_mip, i_trap_mtvec, i_trap_mepc,
    input  i_trap_redirect_ready,
    output o_trap_csr_we, o_trap_csr_waddr, o_trap_csr_wdata,
    output o_trap_stall, o_trap_flush,
    output o_trap_redirect_valid, o_trap_redirect_pc
  );

endinterface

// File: rtl/riscv_core_trap_cause_sel.sv
// Commit-boundary event priority encoder: picks the winning event and
// computes its mcause, mtval and trap-vector target.
module riscv_core_trap_cause_sel
  import riscv_core_trap_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            commit_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  input  logic            ecall,
  input  logic            ebreak,
  input  logic            mret,
  input  logic            illegal,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mip,
  input  logic [XLEN-1:0] mtvec,
  output logic            take,
  output logic            is_mret,
  output logic [XLEN-1:0] cause,
  output logic [XLEN-1:0] tval,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] pend;
  logic [XLEN-1:0] base;
  logic [4:0]      code;
  logic            irq;
  logic            sel_irq, sel_brk, sel_ill;
  logic            sel_ecl, sel_mrt;

  assign pend = mip & mie;
  assign irq  = mstatus[MIE_BIT] & (|pend);

  // one-hot masks so the decoder below never sees overlap
  assign sel_irq = commit_valid & irq;
  assign sel_brk = commit_valid & ~irq & ebreak;
  assign sel_ill = commit_valid & ~irq & ~ebreak & illegal;
  assign sel_ecl = commit_valid & ~irq & ~ebreak
                 & ~illegal & ecall;
  assign sel_mrt = commit_valid & ~irq & ~ebreak
                 & ~illegal & ~ecall & mret;

  assign take    = sel_irq | sel_brk | sel_ill
                 | sel_ecl | sel_mrt;
  assign is_mret = sel_mrt;

  always_comb begin
    code = '0;
    tval = '0;
    unique case (1'b1)
      sel_irq: code = pend[11] ? CAUSE_MEI
                    : pend[3]  ? CAUSE_MSI
                    : CAUSE_MTI;
      sel_brk: begin
        code = CAUSE_BREAK;
        tval = pc;
      end
      sel_ill: begin
        code = CAUSE_ILLEGAL;
        tval = {{(XLEN-32){1'b0}}, instr};
      end
      sel_ecl: code = CAUSE_ECALL;
      default: ;
    endcase
  end

  assign cause = {sel_irq, {(XLEN-6){1'b0}}, code};
  assign base  = {mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    target = base;
    if (VECTORED_EN && mtvec[1:0] == 2'b01 && sel_irq)
      target = base + {{(XLEN-7){1'b0}}, code, 2'b00};
  end

endmodule

// File: rtl/riscv_core_trap_sequencer.sv
// M-mode trap/mret sequencer: stalls and flushes the pipe, streams the
// CSR updates through one write port, then redirects fetch.
module riscv_core_trap_sequencer
  import riscv_core_trap_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit VECTORED_EN = 1'b1
) (
  input logic i_trap_clk,
  input logic i_trap_rst_n,
  riscv_core_trap_sequencer_if.slave bus
);

  trap_state_e     state, state_nxt;
  logic            take, is_mret, accept;
  logic [XLEN-1:0] cause, tval, target;
  logic [XLEN-1:0] pc_q, cause_q, tval_q, tgt_q;
  logic [XLEN-1:0] ms;
  logic            we;
  logic [11:0]     waddr;
  logic [XLEN-1:0] wdata;
  logic            rvalid;
  logic [XLEN-1:0] rpc;

  riscv_core_trap_cause_sel #(
    .XLEN        (XLEN),
    .VECTORED_EN (VECTORED_EN)
  ) u_cause_sel (
    .commit_valid (bus.i_trap_commit_valid),
    .pc           (bus.i_trap_pc),
    .instr        (bus.i_trap_instr),
    .ecall        (bus.i_trap_ecall),
    .ebreak       (bus.i_trap_ebreak),
    .mret         (bus.i_trap_mret),
    .illegal      (bus.i_trap_illegal),
    .mstatus      (bus.i_trap_mstatus),
    .mie          (bus.i_trap_mie),
    .mip          (bus.i_trap_mip),
    .mtvec        (bus.i_trap_mtvec),
    .take         (take),
    .is_mret      (is_mret),
    .cause        (cause),
    .tval         (tval),
    .target       (target)
  );

  // gated by reset so flush/stall read 0 while reset is held
  assign accept = i_trap_rst_n & (state == S_IDLE) & take;

  always_ff @(posedge i_trap_clk or negedge i_trap_rst_n) begin
    if (!i_trap_rst_n) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (accept) state_nxt = is_mret ? S_W_RESTORE : S_W_EPC;
      S_W_EPC:     state_nxt = S_W_CAUSE;
      S_W_CAUSE:   state_nxt = S_W_TVAL;
      S_W_TVAL:    state_nxt = S_W_STATUS;
      S_W_STATUS:  state_nxt = S_REDIRECT;
      S_W_RESTORE: state_nxt = S_REDIRECT;
      S_REDIRECT:
        if (bus.i_trap_redirect_ready) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_trap_clk or negedge i_trap_rst_n) begin
    if (!i_trap_rst_n) begin
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      tgt_q   <= '0;
    end else if (accept) begin
      pc_q    <= bus.i_trap_pc;
      cause_q <= cause;
      tval_q  <= tval;
      tgt_q   <= is_mret ? bus.i_trap_mepc : target;
    end
  end

  always_comb begin
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    rvalid = 1'b0;
    rpc    = '0;
    ms     = bus.i_trap_mstatus;
    case (state)
      S_W_EPC: begin
        we = 1'b1; waddr = CSR_MEPC; wdata = pc_q;
      end
      S_W_CAUSE: begin
        we = 1'b1; waddr = CSR_MCAUSE; wdata = cause_q;
      end
      S_W_TVAL: begin
        we = 1'b1; waddr = CSR_MTVAL; wdata = tval_q;
      end
      S_W_STATUS: begin
        ms[MPIE_BIT]       = bus.i_trap_mstatus[MIE_BIT];
        ms[MIE_BIT]        = 1'b0;
        ms[MPP_HI:MPP_LO]  = 2'b11;
        we = 1'b1; waddr = CSR_MSTATUS; wdata = ms;
      end
      S_W_RESTORE: begin
        ms[MIE_BIT]        = bus.i_trap_mstatus[MPIE_BIT];
        ms[MPIE_BIT]       = 1'b1;
        ms[MPP_HI:MPP_LO]  = 2'b11;
        we = 1'b1; waddr = CSR_MSTATUS; wdata = ms;
      end
      S_REDIRECT: begin
        rvalid = 1'b1; rpc = tgt_q;
      end
      default: ;
    endcase
  end

  assign bus.o_trap_csr_we         = we;
  assign bus.o_trap_csr_waddr      = waddr;
  assign bus.o_trap_csr_wdata      = wdata;
  assign bus.o_trap_redirect_valid = rvalid;
  assign bus.o_trap_redirect_pc    = rpc;
  assign bus.o_trap_flush          = accept;
  assign bus.o_trap_stall          = accept | (state != S_IDLE);

endmodule

// File: tb/tb_riscv_core_trap_sequencer.sv
// Random + directed bench for the trap sequencer against a
// transaction-level model of the expected CSR writes and redirect.
module tb_riscv_core_trap_sequencer;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_core_trap_sequencer_if #(.XLEN(XLEN)) bus ();

  riscv_core_trap_sequencer #(
    .XLEN        (XLEN),
    .VECTORED_EN (1'b1)
  ) dut (
    .i_trap_clk   (clk),
    .i_trap_rst_n (rst_n),
    .bus          (bus)
  );

  typedef struct {
    bit          cv;
    logic [63:0] pc;
    logic [31:0] instr;
    bit          ecall, ebreak, mret, illegal;
    logic [63:0] mstatus, mie, mip, mtvec, mepc;
  } txn_t;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] exp_a[$];
  logic [63:0] exp_d[$];
  logic [63:0] exp_tgt;
  bit          exp_ev;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic txn_t blank();
    txn_t t;
    t.cv = 0; t.pc = 0; t.instr = 0;
    t.ecall = 0; t.ebreak = 0; t.mret = 0; t.illegal = 0;
    t.mstatus = 0; t.mie = 0; t.mip = 0; t.mtvec = 0; t.mepc = 0;
    return t;
  endfunction

  // expected write list and redirect target, straight from the rules
  function automatic void model(input txn_t t);
    logic [63:0] p, base, mc, tv, ms;
    bit irq;
    int code;
    exp_a.delete();
    exp_d.delete();
    p = t.mip & t.mie;
    irq = t.mstatus[3] && (p != 0);
    exp_ev = t.cv && (irq || t.ebreak || t.illegal
                      || t.ecall || t.mret);
    exp_tgt = 0;
    if (!exp_ev) return;
    base = t.mtvec - (t.mtvec % 4);
    if (!irq && !t.ebreak && !t.illegal && !t.ecall) begin
      ms = (t.mstatus & ~64'h1888)
         | (64'(t.mstatus[7]) << 3) | 64'h1880;
      exp_a.push_back(64'h300);
      exp_d.push_back(ms);
      exp_tgt = t.mepc;
      return;
    end
    tv = 0;
    if (irq) begin
      code = p[11] ? 11 : (p[3] ? 3 : 7);
      mc = (64'd1 << 63) + 64'(code);
      if (t.mtvec % 4 == 1) base = base + 64'(4 * code);
    end else if (t.ebreak) begin
      mc = 3; tv = t.pc;
    end else if (t.illegal) begin
      mc = 2; tv = 64'(t.instr);
    end else begin
      mc = 11;
    end
    ms = (t.mstatus & ~64'h1888)
       | (64'(t.mstatus[3]) << 7) | 64'h1800;
    exp_a.push_back(64'h341); exp_d.push_back(t.pc);
    exp_a.push_back(64'h342); exp_d.push_back(mc);
    exp_a.push_back(64'h343); exp_d.push_back(tv);
    exp_a.push_back(64'h300); exp_d.push_back(ms);
    exp_tgt = base;
  endfunction

  task automatic drive(input txn_t t);
    bus.i_trap_commit_valid = t.cv;
    bus.i_trap_pc      = t.pc;
    bus.i_trap_instr   = t.instr;
    bus.i_trap_ecall   = t.ecall;
    bus.i_trap_ebreak  = t.ebreak;
    bus.i_trap_mret    = t.mret;
    bus.i_trap_illegal = t.illegal;
    bus.i_trap_mstatus = t.mstatus;
    bus.i_trap_mie     = t.mie;
    bus.i_trap_mip     = t.mip;
    bus.i_trap_mtvec   = t.mtvec;
    bus.i_trap_mepc    = t.mepc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},    64'(bus.o_trap_csr_we), 0);
    chk({tag, "_waddr"}, 64'(bus.o_trap_csr_waddr), 0);
    chk({tag, "_wdata"}, bus.o_trap_csr_wdata, 0);
    chk({tag, "_stall"}, 64'(bus.o_trap_stall), 0);
    chk({tag, "_flush"}, 64'(bus.o_trap_flush), 0);
    chk({tag, "_rv"},    64'(bus.o_trap_redirect_valid), 0);
    chk({tag, "_rpc"},   bus.o_trap_redirect_pc, 0);
  endtask

  task automatic run_txn(input txn_t t, input int hold,
                         input bit busy_cv);
    model(t);
    @(posedge clk); #1;
    drive(t);
    bus.i_trap_redirect_ready = 0;
    @(negedge clk);
    chk("flush_acc", 64'(bus.o_trap_flush), 64'(exp_ev));
    chk("stall_acc", 64'(bus.o_trap_stall), 64'(exp_ev));
    chk("we_acc", 64'(bus.o_trap_csr_we), 0);
    if (exp_ev) begin
      foreach (exp_a[i]) begin
        @(posedge clk); #1;
        bus.i_trap_commit_valid = busy_cv;
        @(negedge clk);
        chk("we", 64'(bus.o_trap_csr_we), 1);
        chk("waddr", 64'(bus.o_trap_csr_waddr), exp_a[i]);
        chk("wdata", bus.o_trap_csr_wdata, exp_d[i]);
        chk("rv_busy", 64'(bus.o_trap_redirect_valid), 0);
        chk("stall_busy", 64'(bus.o_trap_stall), 1);
        chk("flush_busy", 64'(bus.o_trap_flush), 0);
      end
      for (int k = 0; k <= hold; k++) begin
        @(posedge clk); #1;
        bus.i_trap_redirect_ready = (k == hold);
        @(negedge clk);
        chk("rvalid", 64'(bus.o_trap_redirect_valid), 1);
        chk("rpc", bus.o_trap_redirect_pc, exp_tgt);
        chk("we_redir", 64'(bus.o_trap_csr_we), 0);
        chk("stall_redir", 64'(bus.o_trap_stall), 1);
      end
    end
    @(posedge clk); #1;
    bus.i_trap_commit_valid = 0;
    bus.i_trap_redirect_ready = 0;
    @(negedge clk);
    chk_zero("idle");
  endtask

  initial begin
    txn_t t;
    t = blank();
    drive(t);
    bus.i_trap_redirect_ready = 0;
    #12;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_zero("post_rst");

    t = blank(); t.cv = 1; t.pc = 64'h8000_0010;
    t.mtvec = 64'h8000_0100; t.mstatus = 64'h8; t.ecall = 1;
    run_txn(t, 0, 1'b0);

    t = blank(); t.cv = 1; t.pc = 64'h100;
    t.instr = 32'hFFFF_FFFF; t.illegal = 1; t.mtvec = 64'h400;
    run_txn(t, 1, 1'b1);

    t = blank(); t.cv = 1; t.pc = 64'h3000; t.ecall = 1;
    t.mip = 64'h80; t.mie = 64'h80; t.mstatus = 64'h8;
    t.mtvec = 64'h1001;
    run_txn(t, 0, 1'b1);

    t = blank(); t.cv = 1; t.mret = 1; t.mepc = 64'h2000;
    t.mstatus = 64'h80;
    run_txn(t, 3, 1'b0);

    t = blank(); t.cv = 1; t.pc = 64'h5000;
    t.mip = 64'h800; t.mie = 64'h800; t.mstatus = 64'h0;
    run_txn(t, 0, 1'b0);

    t = blank(); t.cv = 1; t.pc = 64'h44; t.instr = 32'h1234;
    t.ecall = 1; t.ebreak = 1; t.illegal = 1; t.mret = 1;
    run_txn(t, 0, 1'b0);

    // async reset in the middle of a trap sequence
    t = blank(); t.cv = 1; t.pc = 64'h8000_0010; t.ecall = 1;
    t.mstatus = 64'h8; t.mtvec = 64'h8000_0100;
    @(posedge clk); #1;
    drive(t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_waddr", 64'(bus.o_trap_csr_waddr), 64'h342);
    rst_n = 0;
    #1;
    chk_zero("mid_rst");
    bus.i_trap_commit_valid = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_zero("after_rst");
    end

    for (int n = 0; n < 300; n++) begin
      int sel;
      t = blank();
      t.cv = ($urandom_range(0, 7) != 0);
      t.pc = {$urandom, $urandom};
      t.instr = $urandom;
      t.mstatus = {$urandom, $urandom};
      t.mip = 64'h888 & 64'($urandom);
      t.mie = ($urandom_range(0, 2) == 0)
            ? (64'h888 & 64'($urandom)) : 64'h0;
      t.mtvec = {$urandom, $urandom};
      t.mepc = {$urandom, $urandom};
      sel = $urandom_range(0, 5);
      case (sel)
        1: t.ecall = 1;
        2: t.ebreak = 1;
        3: t.illegal = 1;
        4: t.mret = 1;
        5: begin
          t.ecall = 1'($urandom_range(0, 1));
          t.ebreak = 1'($urandom_range(0, 1));
          t.illegal = 1'($urandom_range(0, 1));
          t.mret = 1'($urandom_range(0, 1));
        end
        default: ;
      endcase
      run_txn(t, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_core_trap_sequencer.md
Name: riscv_core_trap_sequencer

Overview:
Machine-mode trap/return sequencer for the RV64 core. It consumes the decoded ecall/ebreak/mret strobes, illegal-instruction flag and pending interrupts at the commit boundary. It sequences the CSR-file updates (mepc, mcause, mtval, mstatus) over a single CSR write port, stalls and flushes the pipeline, and issues a PC redirect to the trap vector or to mepc.

Parameters:
XLEN, 64, data/PC width
VECTORED_EN, 1, 1 = honour mtvec.MODE=1 for interrupts; 0 = always direct

Ports:
i_trap_clk  in  1  core clock
i_trap_rst_n  in  1  async active-low reset
i_trap_commit_valid  in  1  an instruction is at commit this cycle
i_trap_pc  in  XLEN  PC of committing instruction
i_trap_instr  in  32  committing instruction (for mtval on illegal)
i_trap_ecall  in  1  decoded ecall
i_trap_ebreak  in  1  decoded ebreak
i_trap_mret  in  1  decoded mret
i_trap_illegal  in  1  illegal-instruction flag
i_trap_mstatus  in  XLEN  current mstatus
i_trap_mie  in  XLEN  current mie
i_trap_mip  in  XLEN  current mip
i_trap_mtvec  in  XLEN  current mtvec
i_trap_mepc  in  XLEN  current mepc
o_trap_csr_we  out  1  CSR write strobe (owns port while busy)
o_trap_csr_waddr  out  12  CSR address
o_trap_csr_wdata  out  XLEN  CSR write data
o_trap_stall  out  1  freeze fetch/decode/commit
o_trap_flush  out  1  one-cycle pipeline flush pulse
o_trap_redirect_valid  out  1  redirect request
o_trap_redirect_pc  out  XLEN  redirect target
i_trap_redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset (async): state=IDLE; every output 0; captured pc/cause/tval registers 0. Reset mid-sequence aborts to IDLE with no further CSR writes.
- Event evaluation only in IDLE with i_trap_commit_valid=1. Priority: interrupt > ebreak > illegal > ecall > mret. Non-interrupt strobes are mutually exclusive by decode; the bench still checks the priority.
- Interrupt pending = mstatus.MIE(bit3) & |(mip & mie). Cause priority: MEI(11) > MSI(3) > MTI(7). mcause = {1'b1, cause}. On interrupt, mepc = pc, i.e. the committing instruction does not retire; commit is suppressed via flush.
- Exception causes: ebreak=3, illegal=2, ecall=11, mcause bit63=0. mtval: ebreak=pc, illegal=zero-extended instr, ecall/interrupt=0.
- Acceptance cycle (IDLE, event): latch pc/cause/tval/target; o_trap_flush=1 for exactly this cycle; o_trap_stall=1 combinationally in this cycle and in every non-IDLE state.
- Trap FSM, one CSR write per cycle, o_trap_csr_we=1 in each:
  - W_EPC: addr 0x341, data pc.
  - W_CAUSE: addr 0x342.
  - W_TVAL: addr 0x343.
  - W_STATUS: addr 0x300; data = mstatus with MPIE(7)=MIE, MIE=0, MPP(12:11)=2'b11.
  - Then REDIRECT.
- MRET FSM: W_RESTORE writes 0x300 with MIE=MPIE, MPIE=1, MPP=2'b11, then REDIRECT with target = i_trap_mepc latched at acceptance.
- Trap target: base = {mtvec[XLEN-1:2], 2'b00}. If VECTORED_EN & mtvec[1:0]==1 & interrupt, target = base + 4*cause (arithmetic mod 2^XLEN). Otherwise target = base. mtvec[1:0]>=2 is treated as direct.
- REDIRECT: o_trap_redirect_valid=1 with a stable pc until i_trap_redirect_ready. On the handshake cycle, go to IDLE; valid drops next cycle.
- Latency: trap acceptance to first redirect_valid = 5 cycles; mret = 2 cycles.
- Events, including new interrupts, arriving while non-IDLE are ignored; the pipeline is stalled, so none are lost.
- o_trap_csr_we=0 in IDLE and REDIRECT; waddr/wdata=0 when we=0.

Decomposition:
- Package riscv_core_trap_pkg holds:
  - State enum.
  - CSR address constants (MSTATUS 0x300, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343).
  - Cause codes.
  - mstatus bit positions (MIE, MPIE, MPP).
- One sub-module, riscv_core_trap_cause_sel: combinational priority/cause/tval/target encoder feeding the FSM.

Test Plan:
- ecall at pc=0x8000_0010, mtvec=0x8000_0100, MIE=1, no irq -> writes 0x341=0x80000010, 0x342=11, 0x343=0, 0x300 with MIE=0/MPIE=1/MPP=3; redirect 0x80000100 five cycles after acceptance.
- Illegal instr 0xFFFF_FFFF at pc=0x100 -> mcause=2, mtval=0xFFFFFFFF, flush pulse exactly one cycle.
- MTI pending (mip[7]=mie[7]=1, MIE=1), mtvec=0x1001 vectored, commit ecall -> interrupt wins: mcause=0x8000_0000_0000_0007, redirect 0x101C.
- mret with mepc=0x2000, mstatus MPIE=1, MIE=0 -> single write 0x300 with MIE=1, MPIE=1; redirect 0x2000 after 2 cycles; redirect_ready held low 3 cycles -> valid and pc held stable.
- Reset asserted during W_CAUSE -> all outputs 0 immediately, IDLE after release, no further CSR writes.
- MIE=0 with MEI pending, commit plain instruction -> no action, stall=0.
